// File: rtl/hdmiin_framectrl.sv
// hdmiin_framectrl: Wishbone capture controller sequencing the HDMI copy
// engine over a 1-4 frame buffer ring. Define FRAMECTRL_LOCK_EN for buffer lock.
module hdmiin_framectrl #(
    parameter int XBITS = 13,
    parameter int YBITS = 11,
    parameter int AW    = 24
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [2:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_stall,
    output logic             o_wb_ack,
    output logic [31:0]      o_wb_data,
    input  logic             i_frame_stb,
    output logic             o_en,
    output logic [AW-1:0]    o_first_address,
    output logic [AW-1:0]    o_words_per_line,
    output logic [XBITS-1:0] o_first_xpos,
    output logic [XBITS-1:0] o_pix_line,
    output logic [YBITS-1:0] o_first_ypos,
    output logic [YBITS-1:0] o_nlines,
    output logic             o_int
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

    state_t state, state_nx;

    logic             enable, oneshot;
    logic [1:0]       nbuf_m1, live_nbuf_m1;
    logic [AW-1:0]    base, stride, line_words;
    logic [XBITS-1:0] xpos, pix_line;
    logic [YBITS-1:0] ypos, nlines;
    logic [1:0]       cur, last;
    logic             ovf, lock_en;
    logic [1:0]       lock_idx;
    logic [31:0]      frames;
    logic             ack_q;
    logic [31:0]      rdata;
    logic             acc, wr, wr_ctrl;
    logic             arm, complete, load;
    logic [1:0]       nxt0, nxt;
    logic             drop;
    logic [AW-1:0]    nxt_addr;
    logic             unused;

    // (n mod nbuf) for n in 0..4, nbuf given as nbuf-1
    function automatic logic [1:0] wrap(input logic [2:0] n, input logic [1:0] m1);
        logic [1:0] r;
        r = 2'd0;
        case (m1)
            2'd0: r = 2'd0;
            2'd1: r = {1'b0, n[0]};
            2'd2: r = (n == 3'd3) ? 2'd0 : ((n == 3'd4) ? 2'd1 : n[1:0]);
            default: r = n[1:0];
        endcase
        return r;
    endfunction

    assign unused     = ^i_wb_data;
    assign acc        = i_wb_cyc && i_wb_stb;
    assign wr         = acc && i_wb_we;
    assign wr_ctrl    = wr && (i_wb_addr == 3'd0);
    assign arm        = (state == IDLE) && enable;
    assign complete   = (state == RUN) && i_frame_stb;
    assign load       = arm || ((state != IDLE) && i_frame_stb);
    assign o_en       = (state == ARMED) || (state == RUN);
    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q && i_wb_cyc;

    // Next write buffer, skipping a locked one; drop when no free buffer
    always_comb begin
        nxt0 = wrap({1'b0, cur} + 3'd1, live_nbuf_m1);
        nxt  = nxt0;
        drop = 1'b0;
`ifdef FRAMECTRL_LOCK_EN
        if (lock_en && (nxt0 == lock_idx))
            nxt = wrap({1'b0, nxt0} + 3'd1, live_nbuf_m1);
        if (lock_en && ((nxt == lock_idx) || (nxt == cur)))
            drop = 1'b1;
`endif
    end

    // Buffer address: base + index * stride via shift-add
    always_comb begin
        nxt_addr = base
                 + (nxt[0] ? stride : '0)
                 + (nxt[1] ? {stride[AW-2:0], 1'b0} : '0);
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = ARMED;
            ARMED:   if (i_frame_stb) state_nx = RUN;
            RUN:     if (i_frame_stb && (oneshot || !enable)) state_nx = DRAIN;
            DRAIN:   if (i_frame_stb) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // CTRL register; oneshot clears enable when the run ends
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            enable  <= 1'b0;
            oneshot <= 1'b0;
            nbuf_m1 <= 2'd0;
        end else if (wr_ctrl) begin
            enable  <= i_wb_data[0];
            oneshot <= i_wb_data[1];
            nbuf_m1 <= i_wb_data[3:2];
        end else if (complete && oneshot) begin
            enable  <= 1'b0;
        end
    end

`ifdef FRAMECTRL_LOCK_EN
    // Lock fields and sticky overflow; a drop beats a simultaneous clear
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lock_en  <= 1'b0;
            lock_idx <= 2'd0;
            ovf      <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                lock_en  <= i_wb_data[10];
                lock_idx <= i_wb_data[12:11];
            end
            if (complete && drop)
                ovf <= 1'b1;
            else if (wr_ctrl && i_wb_data[9])
                ovf <= 1'b0;
        end
    end
`else
    assign lock_en  = 1'b0;
    assign lock_idx = 2'd0;
    assign ovf      = 1'b0;
`endif

    // Shadow geometry registers written by the CPU
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            base       <= '0;
            stride     <= '0;
            line_words <= '0;
            xpos       <= '0;
            pix_line   <= '0;
            ypos       <= '0;
            nlines     <= '0;
        end else if (wr) begin
            case (i_wb_addr)
                3'd1: base       <= i_wb_data[AW-1:0];
                3'd2: stride     <= i_wb_data[AW-1:0];
                3'd3: line_words <= i_wb_data[AW-1:0];
                3'd4: begin
                    xpos     <= i_wb_data[XBITS-1:0];
                    pix_line <= i_wb_data[16+:XBITS];
                end
                3'd5: begin
                    ypos   <= i_wb_data[YBITS-1:0];
                    nlines <= i_wb_data[16+:YBITS];
                end
                default: ;
            endcase
        end
    end

    // Frame-boundary update of live outputs, rotation and frame count
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            live_nbuf_m1     <= 2'd0;
            o_words_per_line <= '0;
            o_first_xpos     <= '0;
            o_pix_line       <= '0;
            o_first_ypos     <= '0;
            o_nlines         <= '0;
            o_first_address  <= '0;
            cur              <= 2'd0;
            last             <= 2'd0;
            frames           <= '0;
            o_int            <= 1'b0;
        end else begin
            o_int <= complete;
            if (load) begin
                live_nbuf_m1     <= nbuf_m1;
                o_words_per_line <= line_words;
                o_first_xpos     <= xpos;
                o_pix_line       <= pix_line;
                o_first_ypos     <= ypos;
                o_nlines         <= nlines;
            end
            if (arm) begin
                cur             <= 2'd0;
                o_first_address <= base;
            end else if (complete) begin
                last   <= cur;
                frames <= frames + 32'd1;
                if (!drop) begin
                    cur             <= nxt;
                    o_first_address <= nxt_addr;
                end
            end
        end
    end

    // Register read mux
    always_comb begin
        rdata = '0;
        case (i_wb_addr)
            3'd0: begin
                rdata[0]     = enable;
                rdata[1]     = oneshot;
                rdata[3:2]   = nbuf_m1;
                rdata[5:4]   = cur;
                rdata[7:6]   = last;
                rdata[8]     = (state != IDLE);
                rdata[9]     = ovf;
                rdata[10]    = lock_en;
                rdata[12:11] = lock_idx;
            end
            3'd1: rdata[AW-1:0] = base;
            3'd2: rdata[AW-1:0] = stride;
            3'd3: rdata[AW-1:0] = line_words;
            3'd4: begin
                rdata[XBITS-1:0] = xpos;
                rdata[16+:XBITS] = pix_line;
            end
            3'd5: begin
                rdata[YBITS-1:0] = ypos;
                rdata[16+:YBITS] = nlines;
            end
            3'd6: rdata = frames;
            default: ;
        endcase
    end

    // Wishbone ack and read data, one cycle after each request
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q     <= 1'b0;
            o_wb_data <= '0;
        end else begin
            ack_q <= acc;
            if (acc) o_wb_data <= rdata;
        end
    end
endmodule

// File: tb/tb_hdmiin_framectrl.sv
// tb_hdmiin_framectrl: directed bench for hdmiin_framectrl with a
// behavioural reference model compared on every cycle.
module tb_hdmiin_framectrl;
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [2:0]  i_wb_addr = 3'd0;
    logic [31:0] i_wb_data = 32'd0;
    logic        i_frame_stb = 1'b0;
    logic        o_wb_stall, o_wb_ack, o_en, o_int;
    logic [31:0] o_wb_data;
    logic [23:0] o_first_address, o_words_per_line;
    logic [12:0] o_first_xpos, o_pix_line;
    logic [10:0] o_first_ypos, o_nlines;

    int errors = 0;
    int checks = 0;
    int int_cnt = 0;
    bit chk_en = 1'b0;

    hdmiin_framectrl dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .i_frame_stb(i_frame_stb), .o_en(o_en),
        .o_first_address(o_first_address), .o_words_per_line(o_words_per_line),
        .o_first_xpos(o_first_xpos), .o_pix_line(o_pix_line),
        .o_first_ypos(o_first_ypos), .o_nlines(o_nlines), .o_int(o_int)
    );

    always #5 clk = ~clk;

    // model state: 0 idle, 1 armed, 2 run, 3 drain
    int          m_st = 0;
    logic [31:0] m_enable = 0, m_oneshot = 0, m_ovf = 0;
    logic [31:0] m_lock_en = 0, m_lock_idx = 0;
    int          m_nbuf = 1, m_lnbuf = 1, m_cur = 0, m_last = 0;
    logic [31:0] m_base = 0, m_stride = 0, m_lw = 0;
    logic [31:0] m_x = 0, m_pl = 0, m_y = 0, m_nl = 0;
    logic [31:0] m_frames = 0, m_addr = 0;
    logic [31:0] e_lw = 0, e_x = 0, e_pl = 0, e_y = 0, e_nl = 0;
    logic [31:0] e_rdata = 0;
    bit          e_int = 0, e_ackq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return m_enable | (m_oneshot << 1) | (32'(m_nbuf - 1) << 2)
                       | (32'(m_cur) << 4) | (32'(m_last) << 6)
                       | ((m_st != 0 ? 32'd1 : 32'd0) << 8) | (m_ovf << 9)
                       | (m_lock_en << 10) | (m_lock_idx << 11);
            3'd1: return m_base;
            3'd2: return m_stride;
            3'd3: return m_lw;
            3'd4: return m_x | (m_pl << 16);
            3'd5: return m_y | (m_nl << 16);
            3'd6: return m_frames;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_st = 0; m_enable = 0; m_oneshot = 0; m_ovf = 0;
        m_lock_en = 0; m_lock_idx = 0;
        m_nbuf = 1; m_lnbuf = 1; m_cur = 0; m_last = 0;
        m_base = 0; m_stride = 0; m_lw = 0;
        m_x = 0; m_pl = 0; m_y = 0; m_nl = 0;
        m_frames = 0; m_addr = 0;
        e_lw = 0; e_x = 0; e_pl = 0; e_y = 0; e_nl = 0;
        e_rdata = 0; e_int = 0; e_ackq = 0;
    endtask

    // reference model, advanced on each clock from the sampled inputs
    initial forever begin
        @(posedge clk or posedge i_reset);
        if (i_reset) m_reset();
        else begin
            bit acc, ld, dropped;
            int nx;
            logic [31:0] rd, d;
            acc = i_wb_cyc && i_wb_stb;
            d = i_wb_data;
            rd = acc ? m_read(i_wb_addr) : e_rdata;
            ld = 0; dropped = 0; e_int = 0;
            case (m_st)
                0: if (m_enable[0]) begin
                    m_st = 1; ld = 1; m_cur = 0; m_addr = m_base & 32'hFFFFFF;
                end
                1: if (i_frame_stb) begin m_st = 2; ld = 1; end
                2: if (i_frame_stb) begin
                    nx = (m_cur + 1) % m_lnbuf;
`ifdef FRAMECTRL_LOCK_EN
                    if (m_lock_en[0]) begin
                        if (nx == int'(m_lock_idx)) nx = (nx + 1) % m_lnbuf;
                        if (nx == int'(m_lock_idx) || nx == m_cur) dropped = 1;
                    end
`endif
                    m_last = m_cur;
                    m_frames = m_frames + 1;
                    e_int = 1;
                    if (dropped) m_ovf = 1;
                    else begin
                        m_cur = nx;
                        m_addr = (m_base + 32'(nx) * m_stride) & 32'hFFFFFF;
                    end
                    if (m_oneshot[0] || !m_enable[0]) m_st = 3;
                    if (m_oneshot[0]) m_enable = 0;
                    ld = 1;
                end
                default: if (i_frame_stb) begin m_st = 0; ld = 1; end
            endcase
            if (ld) begin
                m_lnbuf = m_nbuf;
                e_lw = m_lw; e_x = m_x; e_pl = m_pl; e_y = m_y; e_nl = m_nl;
            end
            if (acc && i_wb_we) begin
                case (i_wb_addr)
                    3'd0: begin
                        m_enable = 32'(d[0]); m_oneshot = 32'(d[1]);
                        m_nbuf = int'(d[3:2]) + 1;
`ifdef FRAMECTRL_LOCK_EN
                        m_lock_en = 32'(d[10]); m_lock_idx = 32'(d[12:11]);
                        if (d[9] && !dropped) m_ovf = 0;
`endif
                    end
                    3'd1: m_base = d & 32'hFFFFFF;
                    3'd2: m_stride = d & 32'hFFFFFF;
                    3'd3: m_lw = d & 32'hFFFFFF;
                    3'd4: begin m_x = d & 32'h1FFF; m_pl = (d >> 16) & 32'h1FFF; end
                    3'd5: begin m_y = d & 32'h7FF; m_nl = (d >> 16) & 32'h7FF; end
                    default: ;
                endcase
            end
            e_ackq = acc;
            e_rdata = rd;
        end
    end

    // every-cycle comparison of DUT outputs against the model
    initial forever begin
        @(negedge clk);
        if (o_int) int_cnt++;
        if (chk_en) begin
            chk("en", 32'(o_en), (m_st == 1 || m_st == 2) ? 32'd1 : 32'd0);
            chk("int", 32'(o_int), 32'(e_int));
            chk("addr", 32'(o_first_address), m_addr);
            chk("lw", 32'(o_words_per_line), e_lw);
            chk("xpos", 32'(o_first_xpos), e_x);
            chk("pixl", 32'(o_pix_line), e_pl);
            chk("ypos", 32'(o_first_ypos), e_y);
            chk("nlines", 32'(o_nlines), e_nl);
            chk("stall", 32'(o_wb_stall), 32'd0);
            chk("ack", 32'(o_wb_ack), 32'(e_ackq && i_wb_cyc));
            if (e_ackq && i_wb_cyc) chk("rdata", o_wb_data, e_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = a; i_wb_data = d;
        tick();
        i_wb_stb = 0; i_wb_we = 0;
        tick();
        i_wb_cyc = 0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = a;
        tick();
        i_wb_stb = 0;
        @(negedge clk);
        d = o_wb_data;
        tick();
        i_wb_cyc = 0;
    endtask

    task automatic frame();
        i_frame_stb = 1;
        tick();
        i_frame_stb = 0;
    endtask

    task automatic do_reset();
        i_reset = 1;
        tick(); tick();
        i_reset = 0;
        tick();
    endtask

    logic [31:0] rd;
    logic [31:0] addr_tab [5] = '{32'h1000, 32'h1200, 32'h1400, 32'h1000, 32'h1200};
    logic [31:0] last_tab [5] = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd0};

    initial begin
        tick(); tick();
        chk_en = 1;
        i_reset = 0;
        tick();
        for (int a = 0; a < 8; a++) begin
            wb_read(3'(a), rd);
            chk($sformatf("reset_reg%0d", a), rd, 32'd0);
        end
        chk("reset_en", 32'(o_en), 32'd0);
        chk("reset_int", 32'(o_int), 32'd0);

        // three-buffer ring
        int_cnt = 0;
        wb_write(3'd1, 32'h1000);
        wb_write(3'd2, 32'h200);
        wb_write(3'd0, 32'h9);
        chk("armed_addr", 32'(o_first_address), 32'h1000);
        chk("armed_en", 32'(o_en), 32'd1);
        for (int i = 0; i < 5; i++) begin
            frame();
            chk($sformatf("ring_addr%0d", i), 32'(o_first_address), addr_tab[i]);
            if (i > 0) begin
                wb_read(3'd0, rd);
                chk($sformatf("ring_last%0d", i), (rd >> 6) & 32'h3, last_tab[i]);
            end
            tick();
        end
        wb_read(3'd6, rd);
        chk("ring_frames", rd, 32'd4);
        chk("ring_ints", 32'(int_cnt), 32'd4);

        // asynchronous reset while running
        i_reset = 1;
        #1;
        chk("arst_en", 32'(o_en), 32'd0);
        chk("arst_addr", 32'(o_first_address), 32'd0);
        tick(); tick();
        i_reset = 0;
        tick();
        wb_read(3'd6, rd);
        chk("arst_frames", rd, 32'd0);
        wb_read(3'd0, rd);
        chk("arst_ctrl", rd, 32'd0);

        // oneshot capture
        int_cnt = 0;
        wb_write(3'd0, 32'h3);
        frame();
        chk("os_run_en", 32'(o_en), 32'd1);
        frame();
        chk("os_drain_en", 32'(o_en), 32'd0);
        frame();
        tick();
        wb_read(3'd0, rd);
        chk("os_ctrl", rd, 32'h2);
        wb_read(3'd6, rd);
        chk("os_frames", rd, 32'd1);
        chk("os_ints", 32'(int_cnt), 32'd1);
        do_reset();

        // shadow timing of geometry writes
        wb_write(3'd0, 32'h1);
        frame();
        wb_write(3'd4, (32'd640 << 16) | 32'd100);
        tick();
        chk("sh_hold", 32'(o_first_xpos), 32'd0);
        i_frame_stb = 1;
        #1;
        chk("sh_before", 32'(o_first_xpos), 32'd0);
        tick();
        i_frame_stb = 0;
        chk("sh_after", 32'(o_first_xpos), 32'd100);
        chk("sh_pixl", 32'(o_pix_line), 32'd640);
        tick();
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = 3'd4;
        i_wb_data = 32'd200; i_frame_stb = 1;
        tick();
        i_wb_stb = 0; i_wb_we = 0; i_frame_stb = 0;
        chk("sh_coincide", 32'(o_first_xpos), 32'd100);
        tick();
        i_wb_cyc = 0;
        frame();
        chk("sh_later", 32'(o_first_xpos), 32'd200);
        do_reset();

`ifdef FRAMECTRL_LOCK_EN
        begin
            logic [31:0] lk_tab [5] = '{32'h200, 32'h0, 32'h200, 32'h0, 32'h0};
            wb_write(3'd2, 32'h100);
            wb_write(3'd0, 32'h0C09);
            frame();
            for (int i = 0; i < 5; i++) begin
                if (i == 3) wb_write(3'd0, 32'h0C05);
                frame();
                chk($sformatf("lock_addr%0d", i), 32'(o_first_address), lk_tab[i]);
            end
            wb_read(3'd0, rd);
            chk("lock_ovf", (rd >> 9) & 32'h1, 32'd1);
            chk("lock_cur", (rd >> 4) & 32'h3, 32'd0);
            wb_write(3'd0, 32'h0E05);
            wb_read(3'd0, rd);
            chk("lock_ovf_clr", (rd >> 9) & 32'h1, 32'd0);
        end
`else
        wb_write(3'd0, 32'h1E01);
        wb_read(3'd0, rd);
        chk("nolock_ctrl", rd, 32'h101);
`endif
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hdmiin_framectrl.md
# hdmiin_framectrl

Wishbone-slave capture controller that sequences the HDMI input copy engine across a ring of 1–4 frame buffers in memory. It holds the CPU-visible capture registers and drives the copy engine's enable, first-address and geometry inputs, updating them only at frame boundaries. It rotates the write buffer on each end-of-frame strobe, lets the CPU lock one buffer against overwrite, counts completed frames and pulses an interrupt per completed frame. It sits entirely in the bus clock domain, between the CPU bus and the copy engine.

## Interface

- XBITS, 13, width of X-geometry fields
- YBITS, 11, width of Y-geometry fields
- AW, 24, word-address width
- i_clk  in  1  bus clock; the only clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  pipelined Wishbone slave request
- i_wb_addr  in  3  register select
- i_wb_data  in  32  write data; i_wb_sel is not used, all writes are full-word
- o_wb_stall  out  1  tied to 0
- o_wb_ack  out  1  acknowledge
- o_wb_data  out  32  read data
- i_frame_stb  in  1  one-cycle end-of-input-frame pulse, already synchronized into i_clk
- o_en  out  1  capture enable to the copy engine
- o_first_address  out  AW  base of the current write buffer
- o_words_per_line  out  AW  line stride; 0 lets the engine derive it
- o_first_xpos, o_pix_line  out  XBITS  capture window, X
- o_first_ypos, o_nlines  out  YBITS  capture window, Y
- o_int  out  1  one-cycle pulse per completed frame

## Operation

Register map (word index):
- 0 CTRL
  - Write: [0] enable, [1] oneshot, [3:2] nbuf−1, [9] write-1-clears overflow, [10] lock_en, [12:11] lock_idx.
  - Read: the written fields, plus [5:4] cur (current write buffer), [7:6] last (last completed buffer), [8] busy (state≠IDLE), [9] overflow (sticky).
- 1 BASE, AW bits.
- 2 STRIDE, words between buffers, AW bits.
- 3 LINE_WORDS, AW bits.
- 4 [XBITS−1:0] first_xpos, [16+XBITS−1:16] pix_line.
- 5 [YBITS−1:0] first_ypos, [16+YBITS−1:16] nlines.
- 6 FRAMES: 32-bit completed-frame count, read-only, wraps.
- 7 reads 0.
- Unused read bits are 0. Writes to 6 and 7 are ignored.

Shadowing:
- Registers 1–5 and nbuf are shadow copies.
- They load into the live outputs and the live nbuf on every i_frame_stb, and also on the IDLE→ARMED transition.

State machine:
- IDLE: o_en=0. CTRL.enable=1 → ARMED. On entry, cur=0 and o_first_address=BASE.
- ARMED: o_en=1. i_frame_stb → RUN, with no completion and no rotation.
- RUN: o_en=1. Each i_frame_stb is a completion:
  - last←cur, FRAMES+1, o_int=1.
  - cur←next, o_first_address←BASE+next×STRIDE.
  - Then: if oneshot=1 or enable=0 → DRAIN; otherwise stay in RUN.
- DRAIN: o_en=0. The next i_frame_stb → IDLE, with no completion. enable=1 written during DRAIN is remembered and taken at IDLE.

Next-buffer rule:
- next=(cur+1) mod live nbuf.
- If lock is active and next==lock_idx, use the following index instead.
- If that still hits lock_idx or equals cur (nbuf=1 with cur locked, or nbuf=2 with the other buffer locked), the frame is dropped: cur and address are unchanged, overflow←1. The completion count and o_int still fire, and last←cur.
- next×STRIDE is computed by shift-add (index ≤3), truncated to AW bits; address arithmetic wraps modulo 2^AW.

## Timing

- Every output is reset to 0.
- Wishbone:
  - o_wb_ack is 1 exactly one cycle after each accepted stb (i_wb_cyc&&i_wb_stb); back-to-back requests give back-to-back acks.
  - o_wb_data is valid in the ack cycle and reflects state as of the request cycle.
  - o_wb_ack is forced to 0 while i_wb_cyc=0.
- Rotation, shadow load, o_int and the FRAMES increment all take effect in the cycle after i_frame_stb.
- A CPU write in the same cycle as i_frame_stb: the shadow takes the old value at that boundary; the new value applies at the next boundary. An overflow clear coinciding with a drop leaves overflow=1.
- i_frame_stb in IDLE is ignored.
- Reset mid-operation returns to IDLE, clears all registers and counters, and o_en drops immediately (asynchronous).

## Configuration

- FRAMECTRL_LOCK_EN defined: the lock and skip logic is implemented as above.
- Undefined: lock_en and lock_idx are not stored and read 0. Rotation is plain modulo nbuf. overflow never sets and reads 0.

## Test plan

- Reset, then read registers 0–7 → all 0; o_en=0, o_int=0.
- BASE=0x1000, STRIDE=0x200, nbuf=3, enable; send 5 i_frame_stb → addresses 0x1000, 0x1200, 0x1400, 0x1000, 0x1200; last=0,1,2,0; FRAMES=4; 4 o_int pulses.
- oneshot=1, enable, 3 strobes → ARMED→RUN→DRAIN→IDLE; FRAMES=1; o_en low after 2nd strobe; busy=0 after 3rd.
- (FRAMECTRL_LOCK_EN) nbuf=3, lock_idx=1 → sequence 0,2,0,2; nbuf=2, lock_idx=1 → stays 0, overflow=1; write-1-clear → 0.
- Write first_xpos=100 mid-frame → o_first_xpos changes only the cycle after the next i_frame_stb; a write coinciding with the strobe applies one frame later.
- Assert i_reset while in RUN → o_en, o_first_address and FRAMES are 0 in the same cycle; state is IDLE.
